// File: rtl/viterbi_pkg.sv
// rtl/viterbi_pkg.sv - shared constants and trellis helpers for the K=3 rate-1/2 Viterbi codec
package viterbi_pkg;
    localparam int K            = 3;
    localparam logic [K-1:0] G1 = 3'b111;
    localparam logic [K-1:0] G0 = 3'b101;
    localparam int TB_DEPTH_DEF = 16;
    localparam int PM_W_DEF     = 8;
    localparam int PM_INIT      = 16;

    // Symbol emitted when input d is shifted into encoder state s; shared by encoder and trellis
    function automatic logic [1:0] branch_sym(input logic [K-2:0] s, input logic d);
        logic [K-1:0] r;
        r = {d, s};
        return {^(r & G1), ^(r & G0)};
    endfunction

    function automatic logic [1:0] hamming2(input logic [1:0] a, input logic [1:0] b);
        logic [1:0] x;
        x = a ^ b;
        return {1'b0, x[1]} + {1'b0, x[0]};
    endfunction
endpackage

// File: rtl/viterbi_codec_if.sv
// rtl/viterbi_codec_if.sv - encoder/decoder symbol signals of the Viterbi codec
interface viterbi_codec_if;
    logic       enc_enable_i;
    logic       enc_d_in;
    logic       enc_valid_o;
    logic [1:0] enc_d_out;
    logic       dec_enable;
    logic [1:0] dec_d_in;
    logic       dec_d_out;

    modport master (
        output enc_enable_i, enc_d_in, dec_enable, dec_d_in,
        input  enc_valid_o, enc_d_out, dec_d_out
    );

    modport slave (
        input  enc_enable_i, enc_d_in, dec_enable, dec_d_in,
        output enc_valid_o, enc_d_out, dec_d_out
    );
endinterface

// File: rtl/conv_encoder.sv
// rtl/conv_encoder.sv - rate 1/2 K=3 convolutional encoder (g=7,5)
module conv_encoder
    import viterbi_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       d,
    output logic       valid,
    output logic [1:0] d_out
);
    logic [K-2:0] s;

    always_ff @(posedge clk) begin
        if (!rst) begin
            s     <= '0;
            d_out <= '0;
            valid <= 1'b0;
        end else begin
            valid <= enable;
            if (enable) begin
                d_out <= branch_sym(s, d);
                s     <= {d, s[K-2:1]};
            end
        end
    end
endmodule

// File: rtl/viterbi_codec.sv
// rtl/viterbi_codec.sv - convolutional encoder plus 4-state register-exchange Viterbi decoder
module viterbi_codec
    import viterbi_pkg::*;
#(
    parameter int TB_DEPTH = TB_DEPTH_DEF,
    parameter int PM_W     = PM_W_DEF
) (
    input  logic            clk,
    input  logic            rst,
    viterbi_codec_if.slave  bus
);
    logic [PM_W-1:0]     pm   [4];
    logic [TB_DEPTH-1:0] surv [4];
    logic                dec_q;

    logic [PM_W:0] raw [4];
    logic [1:0]    win [4];
    logic [PM_W:0] c0, c1, min_pm;
    logic [1:0]    best;

    conv_encoder u_enc (
        .clk    (clk),
        .rst    (rst),
        .enable (bus.enc_enable_i),
        .d      (bus.enc_d_in),
        .valid  (bus.enc_valid_o),
        .d_out  (bus.enc_d_out)
    );

    // Next state {d,b} is reached from {b,0} or {b,1}; {b,0} wins ties
    always_comb begin
        raw    = '{default: '0};
        win    = '{default: '0};
        c0     = '0;
        c1     = '0;
        min_pm = '0;
        best   = '0;
        for (int i = 0; i < 4; i++) begin
            c0 = (PM_W+1)'(pm[{i[0], 1'b0}])
               + (PM_W+1)'(hamming2(bus.dec_d_in, branch_sym({i[0], 1'b0}, i[1])));
            c1 = (PM_W+1)'(pm[{i[0], 1'b1}])
               + (PM_W+1)'(hamming2(bus.dec_d_in, branch_sym({i[0], 1'b1}, i[1])));
            if (c1 < c0) begin
                raw[i] = c1;
                win[i] = {i[0], 1'b1};
            end else begin
                raw[i] = c0;
                win[i] = {i[0], 1'b0};
            end
        end
        min_pm = raw[0];
        for (int i = 1; i < 4; i++) begin
            if (raw[i] < min_pm) begin
                min_pm = raw[i];
                best   = 2'(i);
            end
        end
    end

    // New MSB of the best survivor is the old survivor's next-to-top bit
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) begin
                pm[i]   <= (i == 0) ? '0 : PM_W'(PM_INIT);
                surv[i] <= '0;
            end
            dec_q <= 1'b0;
        end else if (bus.dec_enable) begin
            for (int i = 0; i < 4; i++) begin
                pm[i]   <= PM_W'(raw[i] - min_pm);
                surv[i] <= {surv[win[i]][TB_DEPTH-2:0], i[1]};
            end
            dec_q <= surv[win[best]][TB_DEPTH-2];
        end
    end

    assign bus.dec_d_out = dec_q;
endmodule

// File: tb/tb_viterbi_codec.sv
// tb/tb_viterbi_codec.sv - self-checking bench for viterbi_codec against a bit-history model
module tb_viterbi_codec;
    localparam int LAT = 15;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   nvec = 0;
    int   nerr = 0;
    bit   hist [$];

    always #5 clk = ~clk;

    viterbi_codec_if bus ();

    viterbi_codec dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [1:0] model_sym(int k);
        bit b0, b1, b2;
        b0 = hist[k];
        b1 = (k >= 1) ? hist[k-1] : 1'b0;
        b2 = (k >= 2) ? hist[k-2] : 1'b0;
        return {b0 ^ b1 ^ b2, b0 ^ b2};
    endfunction

    function automatic logic model_dec(int k);
        return (k >= LAT) ? hist[k-LAT] : 1'b0;
    endfunction

    function automatic int pm_min();
        int m;
        m = int'(dut.pm[0]);
        for (int i = 1; i < 4; i++) if (int'(dut.pm[i]) < m) m = int'(dut.pm[i]);
        return m;
    endfunction

    task automatic drive_idle();
        bus.enc_enable_i = 1'b0;
        bus.enc_d_in     = 1'b0;
        bus.dec_enable   = 1'b0;
        bus.dec_d_in     = 2'b00;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        drive_idle();
        @(negedge clk);
        rst = 1'b1;
        hist.delete();
    endtask

    // Encode one bit, then feed the encoded symbol (optionally corrupted) to the decoder
    task automatic step(input bit d, input logic [1:0] err, output logic [1:0] sym,
                        output logic dout);
        bus.enc_enable_i = 1'b1;
        bus.enc_d_in     = d;
        bus.dec_enable   = 1'b0;
        @(negedge clk);
        sym              = bus.enc_d_out;
        bus.enc_enable_i = 1'b0;
        bus.dec_enable   = 1'b1;
        bus.dec_d_in     = sym ^ err;
        @(negedge clk);
        dout           = bus.dec_d_out;
        bus.dec_enable = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        nvec++;
        if (bus.enc_d_out !== 2'b00 || bus.enc_valid_o !== 1'b0 || bus.dec_d_out !== 1'b0) begin
            nerr++;
            $display("FAIL reset_outputs: got enc=%b v=%b dec=%b, need 00/0/0",
                     bus.enc_d_out, bus.enc_valid_o, bus.dec_d_out);
        end
        for (int i = 0; i < 4; i++) begin
            nvec++;
            if (int'(dut.pm[i]) != ((i == 0) ? 0 : 16)) begin
                nerr++;
                $display("FAIL reset_pm%0d: got %0d, need %0d", i, dut.pm[i], (i == 0) ? 0 : 16);
            end
        end
    endtask

    task automatic test_encoder_vectors();
        bit         din [6] = '{1, 0, 1, 1, 0, 0};
        logic [1:0] exp [6] = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            bus.enc_enable_i = 1'b1;
            bus.enc_d_in     = din[i];
            @(negedge clk);
            nvec++;
            if (bus.enc_d_out !== exp[i] || bus.enc_valid_o !== 1'b1) begin
                nerr++;
                $display("FAIL enc_vec%0d: got %b v=%b, need %b v=1", i, bus.enc_d_out,
                         bus.enc_valid_o, exp[i]);
            end
        end
        bus.enc_enable_i = 1'b0;
        @(negedge clk);
        nvec++;
        if (bus.enc_d_out !== 2'b11 || bus.enc_valid_o !== 1'b0 || bus.dec_d_out !== 1'b0) begin
            nerr++;
            $display("FAIL enc_hold: got %b v=%b dec=%b, need 11 v=0 dec=0",
                     bus.enc_d_out, bus.enc_valid_o, bus.dec_d_out);
        end
    endtask

    task automatic test_loop_clean();
        logic [1:0] sym;
        logic       dout;
        do_reset();
        for (int n = 0; n < 256; n++) begin
            hist.push_back(1'($urandom_range(0, 1)));
            step(hist[n], 2'b00, sym, dout);
            nvec++;
            if (sym !== model_sym(n) || dout !== model_dec(n)) begin
                nerr++;
                $display("FAIL clean_sym%0d: got enc=%b dec=%b, need enc=%b dec=%b",
                         n, sym, dout, model_sym(n), model_dec(n));
            end
        end
    endtask

    task automatic test_loop_errors();
        logic [1:0] sym;
        logic       dout;
        int         pos;
        do_reset();
        pos = $urandom_range(0, 15);
        for (int n = 0; n < 512; n++) begin
            if (n % 32 == 0) pos = n + $urandom_range(0, 15);
            hist.push_back(1'($urandom_range(0, 1)));
            step(hist[n], (n == pos) ? 2'b11 : 2'b00, sym, dout);
            nvec++;
            if (dout !== model_dec(n)) begin
                nerr++;
                $display("FAIL err_sym%0d: got dec=%b, need %b (flip at %0d)",
                         n, dout, model_dec(n), pos);
            end
        end
    endtask

    task automatic test_pm_bounds();
        logic [1:0] sym;
        logic       dout;
        for (int pass = 0; pass < 2; pass++) begin
            do_reset();
            for (int n = 0; n < 1000; n++) begin
                hist.push_back((pass == 0) ? 1'b1 : 1'($urandom_range(0, 1)));
                step(hist[n], 2'b00, sym, dout);
                nvec++;
                if (pm_min() != 0 || dout !== model_dec(n)) begin
                    nerr++;
                    $display("FAIL pm_pass%0d_sym%0d: got min=%0d dec=%b, need min=0 dec=%b",
                             pass, n, pm_min(), dout, model_dec(n));
                end
            end
        end
    endtask

    task automatic test_dec_hold();
        logic [1:0]  sym;
        logic        dout;
        logic        held_out;
        logic [7:0]  held_pm [4];
        do_reset();
        for (int n = 0; n < 80; n++) begin
            if (n == 40) begin
                held_out = bus.dec_d_out;
                for (int i = 0; i < 4; i++) held_pm[i] = dut.pm[i];
                for (int c = 0; c < 5; c++) begin
                    bus.dec_d_in = 2'($urandom_range(0, 3));
                    @(negedge clk);
                    for (int i = 0; i < 4; i++) begin
                        nvec++;
                        if (dut.pm[i] !== held_pm[i] || bus.dec_d_out !== held_out) begin
                            nerr++;
                            $display("FAIL hold_c%0d_pm%0d: got pm=%0d dec=%b, need pm=%0d dec=%b",
                                     c, i, dut.pm[i], bus.dec_d_out, held_pm[i], held_out);
                        end
                    end
                end
            end
            hist.push_back(1'($urandom_range(0, 1)));
            step(hist[n], 2'b00, sym, dout);
            nvec++;
            if (dout !== model_dec(n)) begin
                nerr++;
                $display("FAIL hold_sym%0d: got dec=%b, need %b", n, dout, model_dec(n));
            end
        end
    endtask

    task automatic test_reset_midstream();
        logic [1:0] sym;
        logic       dout;
        do_reset();
        for (int n = 0; n < 30; n++) begin
            hist.push_back(1'b1);
            step(hist[n], 2'b00, sym, dout);
        end
        do_reset();
        nvec++;
        if (bus.enc_d_out !== 2'b00 || bus.enc_valid_o !== 1'b0 || bus.dec_d_out !== 1'b0
            || pm_min() != 0 || int'(dut.pm[3]) != 16) begin
            nerr++;
            $display("FAIL midreset_state: got enc=%b v=%b dec=%b pm3=%0d, need 00/0/0 pm3=16",
                     bus.enc_d_out, bus.enc_valid_o, bus.dec_d_out, dut.pm[3]);
        end
        for (int n = 0; n < 48; n++) begin
            hist.push_back(1'($urandom_range(0, 1)));
            step(hist[n], 2'b00, sym, dout);
            nvec++;
            if (sym !== model_sym(n) || dout !== model_dec(n)) begin
                nerr++;
                $display("FAIL midreset_sym%0d: got enc=%b dec=%b, need enc=%b dec=%b",
                         n, sym, dout, model_sym(n), model_dec(n));
            end
        end
    endtask

    initial begin
        drive_idle();
        test_reset();
        test_encoder_vectors();
        test_loop_clean();
        test_loop_errors();
        test_pm_bounds();
        test_dec_hold();
        test_reset_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
